// File: rtl/iter_signed_div.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per clock, followed by sign fixup. Valid/ready on both sides, one op in flight.
module iter_signed_div #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] dividend_i,
  input  logic signed [WIDTH-1:0] divisor_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_zero,
  output logic                    overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  // Magnitudes carry one extra bit so |-2^(WIDTH-1)| is representable.
  logic [WIDTH:0]   rem_acc, dvd_sh, dvs_mag;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, ovf_pend;
  logic             accept, dvs_is_zero, dvd_is_min;

  logic [WIDTH:0]   shifted, rem_next, dvd_next;
  logic [WIDTH+1:0] trial;
  logic             qbit;

  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH:0] m, input logic neg);
    logic [WIDTH:0] r;
    r = neg ? -m : m;
    return r[WIDTH-1:0];
  endfunction

  assign accept      = (state == IDLE) && in_valid;
  assign dvs_is_zero = ~|divisor_i;
  assign dvd_is_min  = dividend_i[WIDTH-1] && ~|dividend_i[WIDTH-2:0];

  // One restoring step: shift {partial remainder, dividend}, trial-subtract.
  always_comb begin
    shifted  = {rem_acc[WIDTH-1:0], dvd_sh[WIDTH-1]};
    trial    = {1'b0, shifted} - {1'b0, dvs_mag};
    qbit     = ~trial[WIDTH+1];
    rem_next = qbit ? trial[WIDTH:0] : shifted;
    dvd_next = {dvd_sh[WIDTH-1:0], qbit};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = dvs_is_zero ? DONE : CALC;
      end
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && dvs_is_zero) begin
        quotient  <= '1;
        remainder <= dividend_i;
        div_zero  <= 1'b1;
        overflow  <= 1'b0;
      end else if (state == CALC && cnt == '0) begin
        // The -2^(WIDTH-1)/-1 quotient wraps naturally on truncation.
        quotient  <= apply_sign({1'b0, dvd_next[WIDTH-1:0]}, neg_q);
        remainder <= apply_sign(rem_next, neg_r);
        div_zero  <= 1'b0;
        overflow  <= ovf_pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q    <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_r    <= dividend_i[WIDTH-1];
      dvd_sh   <= magnitude(dividend_i);
      dvs_mag  <= magnitude(divisor_i);
      rem_acc  <= '0;
      cnt      <= CW'(WIDTH - 1);
      ovf_pend <= dvd_is_min && (&divisor_i);
    end else if (state == CALC) begin
      rem_acc <= rem_next;
      dvd_sh  <= dvd_next;
      cnt     <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_iter_signed_div.sv
// Scoreboard bench for iter_signed_div: directed divides push expected results,
// an independent monitor pops and compares on each output handshake.
module tb_iter_signed_div;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                reset, in_valid, in_ready, out_valid, out_ready;
  logic                div_zero, overflow;
  logic signed [W-1:0] dividend_i, divisor_i, quotient, remainder;

  typedef struct packed {
    int         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   op_id = 0;

  iter_signed_div #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge after a negedge that sees valid&&ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got q=0x%0h r=0x%0h with nothing expected", quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("quotient#%0d", mon_e.id),  W'(quotient),  mon_e.q);
        check($sformatf("remainder#%0d", mon_e.id), W'(remainder), mon_e.r);
        check($sformatf("div_zero#%0d", mon_e.id),  W'(div_zero),  W'(mon_e.dz));
        check($sformatf("overflow#%0d", mon_e.id),  W'(overflow),  W'(mon_e.ov));
      end
    end
  end

  task automatic divide(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov, input int elat);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("in_ready_before#%0d", op_id), W'(in_ready), W'(1));
    e.id = op_id; e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
    sb.push_back(e);
    op_id++;
    dividend_i = a;
    divisor_i  = b;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency#%0d", e.id), W'(n), W'(elat));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quotient",  W'(quotient),  W'(0));
    check("rst_remainder", W'(remainder), W'(0));

    // a, b, quotient, remainder, div_zero, overflow, latency
    divide(8'd100,  8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9);
    divide(8'h9C,   8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 9);
    divide(8'd100,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9);
    divide(8'h9C,   8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 9);
    divide(8'h80,   8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 9);
    divide(8'h80,   8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 9);
    divide(8'd3,    8'd5,   8'h00, 8'h03, 1'b0, 1'b0, 9);
    divide(8'h7F,   8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 9);
    divide(8'h80,   8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 9);
    divide(8'd5,    8'd0,   8'hFF, 8'h05, 1'b1, 1'b0, 1);
    divide(8'hFF,   8'd0,   8'hFF, 8'hFF, 1'b1, 1'b0, 1);

    // Backpressure: result must hold and ignore new operands while stalled.
    out_ready = 1'b0;
    divide(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 9);
    for (int i = 0; i < 5; i++) begin
      dividend_i = 8'd1;
      divisor_i  = 8'd1;
      in_valid   = 1'b1;
      check($sformatf("bp_out_valid_%0d", i), W'(out_valid), W'(1));
      check($sformatf("bp_in_ready_%0d", i),  W'(in_ready),  W'(0));
      check($sformatf("bp_quotient_%0d", i),  W'(quotient),  8'h0E);
      check($sformatf("bp_remainder_%0d", i), W'(remainder), 8'h02);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", W'(out_valid), W'(0));
    check("bp_release_in_ready",  W'(in_ready),  W'(1));

    // Leave div_zero set so the reset check below is meaningful.
    divide(8'd9, 8'd0, 8'hFF, 8'h09, 1'b1, 1'b0, 1);

    // Reset during the 4th CALC cycle discards the operation.
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready",  W'(in_ready),  W'(1));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_quotient",  W'(quotient),  W'(0));
    check("midrst_remainder", W'(remainder), W'(0));
    check("midrst_div_zero",  W'(div_zero),  W'(0));
    check("midrst_overflow",  W'(overflow),  W'(0));
    divide(8'd50, 8'd6, 8'h08, 8'h02, 1'b0, 1'b0, 9);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_signed_div.md
Name: iter_signed_div

Overview:
- Sequential two's-complement signed divider; the inverse of the team's combinational signed array multiplier.
- Computes quotient and remainder of WIDTH-bit signed operands, one quotient bit per clock, using restoring division on magnitudes followed by sign fixup.
- Sits in the shader ALU path behind a valid/ready handshake, so a multi-cycle divide can stall the issuing stage without affecting the multiplier's single-cycle path.

Parameters:
- WIDTH, 8, operand/result width in bits (signed two's complement); legal range >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- dividend_i  input  WIDTH  signed dividend
- divisor_i  input  WIDTH  signed divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder; sign follows dividend
- div_zero  output  1  divisor was zero
- overflow  output  1  most-negative / -1 case

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- States: IDLE, CALC, DONE.
- Reset (any state, including mid-CALC or DONE):
  - State goes to IDLE; any operation in flight is discarded.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid&&in_ready.
  - On accept, register the operand signs and magnitudes. Magnitudes are WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
  - divisor==0: go directly to DONE with quotient=all ones, remainder=dividend_i, div_zero=1, overflow=0.
  - Otherwise: go to CALC, load the partial remainder with 0 and the bit counter with WIDTH-1.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: shift {partial remainder, dividend magnitude} left by 1, then trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - After exactly WIDTH iterations (counter reaches 0), go to DONE on the same edge.
  - The DONE registers receive the sign-fixed results on that edge:
    - quotient negated iff sign(dividend)!=sign(divisor);
    - remainder negated iff dividend negative;
    - results truncated to WIDTH bits.
- Overflow:
  - dividend = -2^(WIDTH-1) and divisor = -1.
  - quotient = -2^(WIDTH-1) (wraps), remainder=0, overflow=1.
  - Latency is the same as a normal divide.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs held stable until an edge with out_ready=1, then go to IDLE.
  - out_valid drops on the following cycle; in_ready rises on that same cycle.
  - No result is ever dropped or overwritten while out_valid=1.
- Latency, counting edges after the accept edge:
  - Normal and overflow divides: out_valid is high after WIDTH+1 edges, i.e. CALC lasts WIDTH cycles.
  - Divide by zero: out_valid is high 1 edge after accept.
- Throughput:
  - At most one operation in flight; no accept while in CALC or DONE.
  - With out_ready held at 1, back-to-back ops are issued every WIDTH+2 cycles.
- Input stability: in_valid asserted while in_ready=0 has no effect; operands are sampled only on the accept edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, 100/7 -> after 9 edges out_valid=1, quotient=14 (0x0E), remainder=2, div_zero=0, overflow=0.
- Sign combinations:
  - -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2);
  - 100/-7 -> quotient=0xF2, remainder=0x02;
  - -100/-7 -> quotient=0x0E, remainder=0xFE.
- Edge values:
  - -128/-1 -> quotient=0x80, remainder=0, overflow=1, latency 9;
  - -128/1 -> quotient=0x80, overflow=0;
  - 3/5 -> quotient=0, remainder=3.
- Divide by zero: 5/0 -> out_valid=1 one edge after accept, quotient=0xFF, remainder=0x05, div_zero=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid with 100/7 -> outputs stable, in_ready=0 throughout, in_valid pulses ignored.
  - out_ready=1 -> IDLE next cycle.
- Reset mid-CALC: assert reset on the 4th CALC cycle -> next cycle all outputs at reset values, in_ready=1, and a following 50/6 returns quotient=8, remainder=2.
